// File: rtl/sw_sel_cfg_loader.sv
// Config loader for one CGRA switch: stages mux selects from the config bus
// into a shadow buffer and copies them to the active selects on commit.
module sw_sel_cfg_loader #(
  parameter int NUM_MUX      = 4,
  parameter int SEL_WIDTH    = 3,
  parameter int MAX_SEL      = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int CFG_ID_WIDTH = 8,
  parameter int CFG_ID       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [DATA_WIDTH-1:0]        cfg_data,
  input  logic                         cfg_last,
  input  logic                         cfg_commit,
  input  logic                         cfg_err_clr,
  output logic [NUM_MUX*SEL_WIDTH-1:0] sel_out,
  output logic                         loaded,
  output logic                         cfg_done,
  output logic                         cfg_err
);

  localparam int PBITS = NUM_MUX * SEL_WIDTH;
  localparam int WORDS = (PBITS + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int SW    = WORDS * DATA_WIDTH;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, SKIP, PAYLOAD, LOADED} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    stg;
  logic [SW-1:0]    stg_nxt;
  logic [PBITS-1:0] shadow;
  logic [PBITS-1:0] sel_fix;
  logic             bad;
  logic             xfer;
  logic             id_hit;
  logic             at_end;

  assign cfg_ready = (state != LOADED);
  assign xfer      = cfg_valid && cfg_ready;
  assign id_hit    = cfg_data[CFG_ID_WIDTH-1:0] == CFG_ID_WIDTH'(CFG_ID);
  assign at_end    = (cnt == CW'(WORDS - 1));

  always_comb begin
    stg_nxt = stg;
    for (int k = 0; k < WORDS; k++)
      if (cnt == CW'(k))
        stg_nxt[k*DATA_WIDTH +: DATA_WIDTH] = cfg_data;
  end

  // Out-of-range selects are forced to input 0 rather than passed through.
  always_comb begin
    sel_fix = '0;
    bad     = 1'b0;
    for (int i = 0; i < NUM_MUX; i++) begin
      if (shadow[i*SEL_WIDTH +: SEL_WIDTH] > SEL_WIDTH'(MAX_SEL))
        bad = 1'b1;
      else
        sel_fix[i*SEL_WIDTH +: SEL_WIDTH] = shadow[i*SEL_WIDTH +: SEL_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      stg      <= '0;
      shadow   <= '0;
      sel_out  <= '0;
      loaded   <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      // Later set assignments override this clear.
      if (cfg_err_clr) cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            cnt <= '0;
            if (id_hit && !cfg_last) state <= PAYLOAD;
            else if (id_hit)         cfg_err <= 1'b1;
            else if (!cfg_last)      state <= SKIP;
          end
        end
        SKIP: begin
          if (xfer && cfg_last) state <= IDLE;
        end
        PAYLOAD: begin
          if (xfer) begin
            stg <= stg_nxt;
            if (!at_end) begin
              if (cfg_last) begin
                cfg_err <= 1'b1;
                state   <= IDLE;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else if (cfg_last) begin
              shadow <= stg_nxt[PBITS-1:0];
              loaded <= 1'b1;
              state  <= LOADED;
            end else begin
              cfg_err <= 1'b1;
              stg     <= '0;
              state   <= SKIP;
            end
          end
        end
        LOADED: begin
          if (cfg_commit) begin
            sel_out  <= sel_fix;
            loaded   <= 1'b0;
            cfg_done <= 1'b1;
            state    <= IDLE;
            if (bad) cfg_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_sel_cfg_loader.sv
// Bench for sw_sel_cfg_loader: directed scenarios plus randomized packets
// checked against a packet-level reference model.
module tb_sw_sel_cfg_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        cfg_commit = 1'b0;
  logic        cfg_err_clr = 1'b0;
  logic [11:0] sel_out;
  logic        loaded;
  logic        cfg_done;
  logic        cfg_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [11:0] exp_sel;

  always #5 clk = ~clk;

  sw_sel_cfg_loader #(.CFG_ID(5)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last),
    .cfg_commit(cfg_commit), .cfg_err_clr(cfg_err_clr),
    .sel_out(sel_out), .loaded(loaded),
    .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  // Reference: each 3-bit field above 6 becomes 0 and flags an error.
  function automatic logic [11:0] model_sel(input logic [15:0] p);
    int v;
    model_sel = '0;
    for (int i = 0; i < 4; i++) begin
      v = (p >> (3 * i)) % 8;
      if (v <= 6) model_sel = model_sel | 12'(v << (3 * i));
    end
  endfunction

  function automatic logic model_bad(input logic [15:0] p);
    model_bad = 1'b0;
    for (int i = 0; i < 4; i++)
      if ((p >> (3 * i)) % 8 > 6) model_bad = 1'b1;
  endfunction

  task automatic send(input logic [15:0] d, input logic l);
    tests_run++;
    if (cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_ready: cfg_ready=%b required 1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
  endtask

  task automatic clr_err();
    cfg_err_clr = 1'b1;
    @(posedge clk); #1;
    cfg_err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests_run++;
    if ({sel_out, loaded, cfg_done, cfg_err, cfg_ready} !== {12'h0, 4'b0001}) begin
      tests_failed++;
      $display("FAIL reset: sel=%h ld=%b dn=%b er=%b rdy=%b required 0 0 0 0 1",
               sel_out, loaded, cfg_done, cfg_err, cfg_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    send(16'h0005, 1'b0);
    send(16'h04C6, 1'b1);
    tests_run++;
    if (loaded !== 1'b1 || cfg_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL normal_loaded: loaded=%b rdy=%b required 1 0", loaded, cfg_ready);
    end
    @(posedge clk); #1;
    commit();
    tests_run++;
    if (sel_out !== 12'h4C6 || cfg_done !== 1'b1 || loaded !== 1'b0 || cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL normal_commit: sel=%h dn=%b ld=%b er=%b required 4c6 1 0 0",
               sel_out, cfg_done, loaded, cfg_err);
    end
    @(posedge clk); #1;
    tests_run++;
    if (cfg_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL normal_done_pulse: cfg_done=%b required 0", cfg_done);
    end
  endtask

  task automatic test_foreign();
    logic [15:0] w;
    w = 16'($urandom);
    w[7:0] = 8'h09;
    send(w, 1'b0);
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      w[7:0] = 8'h05;
      send(w, i == 2);
    end
    tests_run++;
    if (loaded !== 1'b0 || sel_out !== 12'h4C6) begin
      tests_failed++;
      $display("FAIL foreign_skip: loaded=%b sel=%h required 0 4c6", loaded, sel_out);
    end
    send(16'h0005, 1'b0);
    send(16'h0123, 1'b1);
    commit();
    tests_run++;
    if (sel_out !== 12'h123) begin
      tests_failed++;
      $display("FAIL foreign_after: sel=%h required 123", sel_out);
    end
  endtask

  task automatic test_illegal();
    send(16'h0005, 1'b0);
    send(16'h04C6, 1'b1);
    commit();
    send(16'h0005, 1'b0);
    send(16'h04FE, 1'b1);
    commit();
    tests_run++;
    if (sel_out !== 12'h4C6 || cfg_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_sel: sel=%h err=%b required 4c6 1", sel_out, cfg_err);
    end
    clr_err();
    tests_run++;
    if (cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_clr: err=%b required 0", cfg_err);
    end
  endtask

  task automatic test_backpressure();
    send(16'h0005, 1'b0);
    send(16'h0123, 1'b1);
    cfg_valid = 1'b1;
    cfg_data  = 16'h0005;
    cfg_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (cfg_ready !== 1'b0 || sel_out !== 12'h4C6 || loaded !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold: rdy=%b sel=%h ld=%b required 0 4c6 1",
                 cfg_ready, sel_out, loaded);
      end
    end
    commit();
    tests_run++;
    if (cfg_ready !== 1'b1 || sel_out !== 12'h123) begin
      tests_failed++;
      $display("FAIL bp_commit: rdy=%b sel=%h required 1 123", cfg_ready, sel_out);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    // 0x0A31 does not carry id 5, so it only loads if the header was taken.
    send(16'h0A31, 1'b1);
    tests_run++;
    if (loaded !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept: loaded=%b required 1", loaded);
    end
    commit();
    tests_run++;
    if (sel_out !== model_sel(16'h0A31)) begin
      tests_failed++;
      $display("FAIL bp_sel: sel=%h required %h", sel_out, model_sel(16'h0A31));
    end
  endtask

  task automatic test_protocol();
    exp_sel = sel_out;
    send(16'h1205, 1'b1);
    tests_run++;
    if (cfg_err !== 1'b1 || loaded !== 1'b0 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL proto_hdr_last: err=%b ld=%b rdy=%b required 1 0 1",
               cfg_err, loaded, cfg_ready);
    end
    clr_err();
    commit();
    tests_run++;
    if (sel_out !== exp_sel || cfg_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL proto_idle_commit: sel=%h dn=%b required %h 0",
               sel_out, cfg_done, exp_sel);
    end
    send(16'h0005, 1'b0);
    commit();
    tests_run++;
    if (sel_out !== exp_sel || cfg_done !== 1'b0 || loaded !== 1'b0) begin
      tests_failed++;
      $display("FAIL proto_payload_commit: sel=%h dn=%b ld=%b required %h 0 0",
               sel_out, cfg_done, loaded, exp_sel);
    end
    send(16'h0011, 1'b1);
    commit();
    tests_run++;
    if (sel_out !== 12'h011 || cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL proto_resume: sel=%h err=%b required 011 0", sel_out, cfg_err);
    end
  endtask

  task automatic test_async_reset();
    send(16'h0005, 1'b1);
    send(16'h0005, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (sel_out !== 12'h0 || loaded !== 1'b0 || cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_mid: sel=%h ld=%b err=%b required 0 0 0",
               sel_out, loaded, cfg_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send(16'h0005, 1'b0);
    send(16'h0162, 1'b1);
    tests_run++;
    if (loaded !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_header: loaded=%b required 1", loaded);
    end
    commit();
    tests_run++;
    if (sel_out !== 12'h162) begin
      tests_failed++;
      $display("FAIL arst_load: sel=%h required 162", sel_out);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (sel_out !== 12'h0 || cfg_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_after_commit: sel=%h dn=%b required 0 0", sel_out, cfg_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] hdr;
    logic [15:0] pay;
    logic        mine;
    int          n;
    exp_sel = sel_out;
    for (int it = 0; it < 40; it++) begin
      mine = ($urandom_range(0, 2) != 0);
      hdr  = 16'($urandom);
      if (mine) hdr[7:0] = 8'h05;
      else if (hdr[7:0] == 8'h05) hdr[7:0] = 8'h06;
      if (mine) begin
        pay = 16'($urandom);
        send(hdr, 1'b0);
        send(pay, 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk); #1;
        end
        commit();
        exp_sel = model_sel(pay);
        tests_run++;
        if (sel_out !== exp_sel || cfg_err !== model_bad(pay) || cfg_done !== 1'b1) begin
          tests_failed++;
          $display("FAIL rand_commit[%0d]: pay=%h sel=%h err=%b dn=%b required %h %b 1",
                   it, pay, sel_out, cfg_err, cfg_done, exp_sel, model_bad(pay));
        end
        clr_err();
      end else begin
        n = $urandom_range(0, 3);
        send(hdr, n == 0);
        for (int j = 1; j <= n; j++) begin
          pay = 16'($urandom);
          send(pay, j == n);
        end
        commit();
        tests_run++;
        if (sel_out !== exp_sel || loaded !== 1'b0 || cfg_done !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_foreign[%0d]: sel=%h ld=%b dn=%b required %h 0 0",
                   it, sel_out, loaded, cfg_done, exp_sel);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_foreign();
    test_illegal();
    test_backpressure();
    test_protocol();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
